// File: rtl/checkout_pkg.sv
// Shared types and width helpers for the checkout accumulator datapath.
package checkout_pkg;

    localparam int DEF_COST_W = 8;
    localparam int DEF_QTY_W  = 4;
    localparam int DEF_SUM_W  = 21;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    function automatic int prod_w(input int cw, input int qw);
        return cw + qw;
    endfunction

    function automatic int max_w(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/checkout_accumulator_if.sv
// Command/status bundle between keypad front end, accumulator and display logic.
interface checkout_accumulator_if
    import checkout_pkg::*;
#(
    parameter int COST_W = DEF_COST_W,
    parameter int QTY_W  = DEF_QTY_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic                                  enter;
    logic [COST_W-1:0]                     cost;
    logic [QTY_W-1:0]                      qty;
    logic                                  void_last;
    logic                                  total;
    logic                                  clear;
    logic                                  ready;
    logic                                  line_valid;
    logic [prod_w(COST_W, QTY_W)-1:0]      line_amount;
    logic [SUM_W-1:0]                      sum;
    logic [CNT_W-1:0]                      item_count;
    logic                                  total_valid;
    logic                                  overflow;

    modport master (
        output enter, cost, qty, void_last, total, clear,
        input  ready, line_valid, line_amount, sum, item_count, total_valid, overflow
    );

    modport slave (
        input  enter, cost, qty, void_last, total, clear,
        output ready, line_valid, line_amount, sum, item_count, total_valid, overflow
    );

endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// fixed QTY_W-cycle latency after start; done pulses as the product settles.
module shift_add_mult
    import checkout_pkg::*;
#(
    parameter int COST_W = DEF_COST_W,
    parameter int QTY_W  = DEF_QTY_W
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          start,
    input  logic [COST_W-1:0]             a,
    input  logic [QTY_W-1:0]              b,
    output logic                          busy,
    output logic                          done,
    output logic [prod_w(COST_W, QTY_W)-1:0] product
);

    localparam int P_W = prod_w(COST_W, QTY_W);
    localparam int C_W = $clog2(QTY_W + 1);

    logic [P_W-1:0]   acc_q, acc_d;
    logic [P_W-1:0]   mcand_q, mcand_d;
    logic [QTY_W-1:0] mplier_q, mplier_d;
    logic [C_W-1:0]   cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = '0;
            mcand_d  = P_W'(a);
            mplier_d = b;
            cnt_d    = C_W'(QTY_W);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - C_W'(1);
            done_d   = (cnt_q == C_W'(1));
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/checkout_accumulator.sv
// Cash-register datapath: cost*qty per line into a saturating running total,
// with single-level void, finalise and clear.
module checkout_accumulator
    import checkout_pkg::*;
#(
    parameter int COST_W = DEF_COST_W,
    parameter int QTY_W  = DEF_QTY_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  CLK,
    input  logic                  reset,
    checkout_accumulator_if.slave bus
);

    localparam int P_W = prod_w(COST_W, QTY_W);
    localparam int A_W = max_w(SUM_W, P_W) + 1;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [P_W-1:0]   line_amount_q, line_amount_d;
    logic [CNT_W-1:0] item_count_q, item_count_d;
    logic             last_ok_q, last_ok_d;
    logic             overflow_q, overflow_d;
    logic             line_valid_q, line_valid_d;
    logic             do_clear;
    logic             mul_start, mul_busy, mul_done;
    logic [P_W-1:0]   mul_product;
    logic [A_W-1:0]   acc_wide;

    shift_add_mult #(.COST_W(COST_W), .QTY_W(QTY_W)) u_mult (
        .CLK     (CLK),
        .reset   (reset),
        .start   (mul_start),
        .a       (bus.cost),
        .b       (bus.qty),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        line_amount_d = line_amount_q;
        item_count_d  = item_count_q;
        last_ok_d     = last_ok_q;
        overflow_d    = overflow_q;
        line_valid_d  = 1'b0;
        mul_start     = 1'b0;
        do_clear      = 1'b0;
        acc_wide      = A_W'(sum_q) + A_W'(mul_product);

        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    do_clear = 1'b1;
                end else if (bus.total) begin
                    state_d = DONE;
                end else if (bus.void_last) begin
                    // A saturated total no longer reflects the lines, so void is refused.
                    if (last_ok_q && !overflow_q) begin
                        sum_d        = sum_q - SUM_W'(line_amount_q);
                        item_count_d = item_count_q - CNT_W'(1);
                        last_ok_d    = 1'b0;
                    end
                end else if (bus.enter && bus.qty != '0) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (mul_done) state_d = ACC;
            end
            ACC: begin
                if ((acc_wide >> SUM_W) != '0) begin
                    sum_d      = '1;
                    overflow_d = 1'b1;
                end else begin
                    sum_d = acc_wide[SUM_W-1:0];
                end
                line_amount_d = mul_product;
                if (item_count_q != '1) item_count_d = item_count_q + CNT_W'(1);
                last_ok_d    = 1'b1;
                line_valid_d = 1'b1;
                state_d      = IDLE;
            end
            DONE: begin
                if (bus.clear) do_clear = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (do_clear) begin
            state_d       = IDLE;
            sum_d         = '0;
            line_amount_d = '0;
            item_count_d  = '0;
            last_ok_d     = 1'b0;
            overflow_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= IDLE;
            sum_q         <= '0;
            line_amount_q <= '0;
            item_count_q  <= '0;
            last_ok_q     <= 1'b0;
            overflow_q    <= 1'b0;
            line_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            line_amount_q <= line_amount_d;
            item_count_q  <= item_count_d;
            last_ok_q     <= last_ok_d;
            overflow_q    <= overflow_d;
            line_valid_q  <= line_valid_d;
        end
    end

    // The multiplier is never busy in IDLE; the term just keeps ready honest.
    assign bus.ready       = (state_q == IDLE) && !mul_busy;
    assign bus.total_valid = (state_q == DONE);
    assign bus.line_valid  = line_valid_q;
    assign bus.line_amount = line_amount_q;
    assign bus.sum         = sum_q;
    assign bus.item_count  = item_count_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_checkout_accumulator.sv
// Directed bench: default-width DUT plus an 8-bit-sum DUT for saturation.
module tb_checkout_accumulator;

    logic CLK = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    checkout_accumulator_if                bus ();
    checkout_accumulator_if #(.SUM_W(8))   bus8 ();

    checkout_accumulator dut (.CLK(CLK), .reset(reset), .bus(bus.slave));
    checkout_accumulator #(.SUM_W(8)) dut8 (.CLK(CLK), .reset(reset), .bus(bus8.slave));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enter = 0; bus.cost = 0; bus.qty = 0; bus.void_last = 0; bus.total = 0; bus.clear = 0;
        bus8.enter = 0; bus8.cost = 0; bus8.qty = 0; bus8.void_last = 0; bus8.total = 0; bus8.clear = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic wait_line(input string nm);
        int n = 0;
        while (bus.line_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_assert++;
        if (n >= 20) begin n_fail++; $display("FAIL %s_timeout: line_valid never seen after %0d cycles", nm, n); end
    endtask

    task automatic add_item(input logic [7:0] c, input logic [3:0] q, input string nm);
        bus.enter = 1; bus.cost = c; bus.qty = q;
        tick();
        bus.enter = 0;
        wait_line(nm);
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++;
        if (bus.ready !== 1 || bus.line_valid !== 0 || bus.sum !== 0 || bus.item_count !== 0 ||
            bus.line_amount !== 0 || bus.total_valid !== 0 || bus.overflow !== 0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%0b lv=%0b sum=%0d cnt=%0d la=%0d tv=%0b ovf=%0b expected ready=1 rest 0",
                     bus.ready, bus.line_valid, bus.sum, bus.item_count, bus.line_amount, bus.total_valid, bus.overflow);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.enter = 1; bus.cost = 25; bus.qty = 2;
        tick();  // edge 0
        bus.enter = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_assert++;
            if (bus.ready !== 0 || bus.line_valid !== 0) begin
                n_fail++;
                $display("FAIL single_busy_edge%0d: ready=%0b lv=%0b expected 0 0", k, bus.ready, bus.line_valid);
            end
        end
        tick();  // edge 6
        n_assert++;
        if (bus.line_valid !== 1 || bus.sum !== 50 || bus.line_amount !== 50 || bus.item_count !== 1 || bus.ready !== 1) begin
            n_fail++;
            $display("FAIL single_edge6: lv=%0b sum=%0d la=%0d cnt=%0d ready=%0b expected 1 50 50 1 1",
                     bus.line_valid, bus.sum, bus.line_amount, bus.item_count, bus.ready);
        end
        tick();
        n_assert++;
        if (bus.line_valid !== 0) begin n_fail++; $display("FAIL single_pulse_width: lv=%0b expected 0", bus.line_valid); end
    endtask

    task automatic test_total();
        do_reset();
        add_item(25, 2, "total_a");
        add_item(10, 2, "total_b");
        bus.total = 1; tick(); bus.total = 0;
        n_assert++;
        if (bus.sum !== 70 || bus.item_count !== 2 || bus.total_valid !== 1 || bus.ready !== 0) begin
            n_fail++;
            $display("FAIL total_done: sum=%0d cnt=%0d tv=%0b ready=%0b expected 70 2 1 0",
                     bus.sum, bus.item_count, bus.total_valid, bus.ready);
        end
        bus.enter = 1; bus.cost = 5; bus.qty = 3; tick(); bus.enter = 0;
        bus.void_last = 1; tick(); bus.void_last = 0;
        repeat (6) tick();
        n_assert++;
        if (bus.sum !== 70 || bus.item_count !== 2 || bus.total_valid !== 1 || bus.line_amount !== 20) begin
            n_fail++;
            $display("FAIL total_frozen: sum=%0d cnt=%0d tv=%0b la=%0d expected 70 2 1 20",
                     bus.sum, bus.item_count, bus.total_valid, bus.line_amount);
        end
        bus.clear = 1; tick(); bus.clear = 0;
        n_assert++;
        if (bus.sum !== 0 || bus.item_count !== 0 || bus.total_valid !== 0 || bus.ready !== 1 || bus.line_amount !== 0) begin
            n_fail++;
            $display("FAIL total_clear: sum=%0d cnt=%0d tv=%0b ready=%0b la=%0d expected 0 0 0 1 0",
                     bus.sum, bus.item_count, bus.total_valid, bus.ready, bus.line_amount);
        end
    endtask

    task automatic test_void();
        do_reset();
        bus.void_last = 1; tick(); bus.void_last = 0;
        n_assert++;
        if (bus.sum !== 0 || bus.item_count !== 0) begin
            n_fail++; $display("FAIL void_empty: sum=%0d cnt=%0d expected 0 0", bus.sum, bus.item_count);
        end
        add_item(25, 2, "void_a");
        add_item(10, 2, "void_b");
        bus.void_last = 1; tick(); bus.void_last = 0;
        n_assert++;
        if (bus.sum !== 50 || bus.item_count !== 1 || bus.line_valid !== 0 || bus.ready !== 1) begin
            n_fail++;
            $display("FAIL void_first: sum=%0d cnt=%0d lv=%0b ready=%0b expected 50 1 0 1",
                     bus.sum, bus.item_count, bus.line_valid, bus.ready);
        end
        bus.void_last = 1; tick(); bus.void_last = 0;
        n_assert++;
        if (bus.sum !== 50 || bus.item_count !== 1) begin
            n_fail++; $display("FAIL void_second: sum=%0d cnt=%0d expected 50 1", bus.sum, bus.item_count);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        do_reset();
        bus8.enter = 1; bus8.cost = 255; bus8.qty = 15; tick(); bus8.enter = 0;
        while (bus8.line_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_assert++;
        if (n >= 20) begin n_fail++; $display("FAIL ovf_timeout: line_valid never seen after %0d cycles", n); end
        n_assert++;
        if (bus8.sum !== 8'd255 || bus8.overflow !== 1 || bus8.line_amount !== 12'd3825 || bus8.item_count !== 1) begin
            n_fail++;
            $display("FAIL ovf_saturate: sum=%0d ovf=%0b la=%0d cnt=%0d expected 255 1 3825 1",
                     bus8.sum, bus8.overflow, bus8.line_amount, bus8.item_count);
        end
        bus8.void_last = 1; tick(); bus8.void_last = 0;
        n_assert++;
        if (bus8.sum !== 8'd255 || bus8.item_count !== 1 || bus8.overflow !== 1) begin
            n_fail++;
            $display("FAIL ovf_void_ignored: sum=%0d cnt=%0d ovf=%0b expected 255 1 1", bus8.sum, bus8.item_count, bus8.overflow);
        end
        bus8.clear = 1; tick(); bus8.clear = 0;
        n_assert++;
        if (bus8.overflow !== 0 || bus8.sum !== 0) begin
            n_fail++; $display("FAIL ovf_clear: ovf=%0b sum=%0d expected 0 0", bus8.overflow, bus8.sum);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        bus.enter = 1; bus.cost = 7; bus.qty = 0; tick(); bus.enter = 0;
        n_assert++;
        if (bus.ready !== 1 || bus.sum !== 0 || bus.item_count !== 0) begin
            n_fail++; $display("FAIL qty0: ready=%0b sum=%0d cnt=%0d expected 1 0 0", bus.ready, bus.sum, bus.item_count);
        end
        add_item(25, 2, "prio_setup");
        bus.enter = 1; bus.clear = 1; bus.cost = 10; bus.qty = 2; tick();
        bus.enter = 0; bus.clear = 0;
        n_assert++;
        if (bus.ready !== 1 || bus.sum !== 0) begin
            n_fail++; $display("FAIL prio_clear: ready=%0b sum=%0d expected 1 0", bus.ready, bus.sum);
        end
        repeat (7) tick();
        n_assert++;
        if (bus.sum !== 0 || bus.item_count !== 0 || bus.ready !== 1) begin
            n_fail++; $display("FAIL prio_no_mul: sum=%0d cnt=%0d ready=%0b expected 0 0 1", bus.sum, bus.item_count, bus.ready);
        end
        bus.enter = 1; bus.cost = 25; bus.qty = 2; tick(); bus.enter = 0;
        tick();
        bus.enter = 1; bus.cost = 10; bus.qty = 3; tick(); bus.enter = 0;
        wait_line("mul_ignore");
        n_assert++;
        if (bus.sum !== 50 || bus.item_count !== 1) begin
            n_fail++; $display("FAIL mul_ignore_line: sum=%0d cnt=%0d expected 50 1", bus.sum, bus.item_count);
        end
        repeat (8) tick();
        n_assert++;
        if (bus.sum !== 50 || bus.item_count !== 1 || bus.ready !== 1) begin
            n_fail++; $display("FAIL mul_ignore_after: sum=%0d cnt=%0d ready=%0b expected 50 1 1", bus.sum, bus.item_count, bus.ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_item(1, 1, "b2b_a");
        add_item(2, 15, "b2b_b");
        add_item(255, 15, "b2b_c");
        n_assert++;
        if (bus.sum !== 3856 || bus.item_count !== 3 || bus.line_amount !== 3825 || bus.overflow !== 0) begin
            n_fail++;
            $display("FAIL back_to_back: sum=%0d cnt=%0d la=%0d ovf=%0b expected 3856 3 3825 0",
                     bus.sum, bus.item_count, bus.line_amount, bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_reset();
        add_item(4, 4, "rmid_setup");
        bus.enter = 1; bus.cost = 25; bus.qty = 2; tick(); bus.enter = 0;  // edge 0
        tick();                                                           // edge 1
        reset = 1; tick(); reset = 0;                                     // edge 2
        n_assert++;
        if (bus.ready !== 1 || bus.line_valid !== 0 || bus.sum !== 0 || bus.item_count !== 0 ||
            bus.line_amount !== 0 || bus.total_valid !== 0 || bus.overflow !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_state: ready=%0b lv=%0b sum=%0d cnt=%0d la=%0d expected 1 0 0 0 0",
                     bus.ready, bus.line_valid, bus.sum, bus.item_count, bus.line_amount);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.line_valid === 1'b1) seen++;
        end
        n_assert++;
        if (seen != 0 || bus.sum !== 0 || bus.item_count !== 0) begin
            n_fail++; $display("FAIL reset_mid_abort: pulses=%0d sum=%0d cnt=%0d expected 0 0 0", seen, bus.sum, bus.item_count);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_total();
        test_void();
        test_overflow();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
